// File: rtl/gray_fifo_rd_side.sv
// gray_fifo_rd_side: read-side Gray pointer manager (wptr sync copy, rptr, empty/level/err, pop handshake)
module gray_fifo_rd_side #(
  parameter int width = 4,
  parameter int speed = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] WPTR_G,
  input  logic             RD_READY,
  output logic             RD_VALID,
  output logic [width-2:0] RADDR,
  output logic [width-1:0] RPTR_G,
  output logic             EMPTY,
  output logic [width-1:0] LEVEL,
  output logic             ERR
);
  localparam logic [width-1:0] half = {1'b1, {(width-1){1'b0}}};
  logic [width-1:0] wq_q, rb_q, rptr_q, wb, rb_d;
  logic err_q, pop;
  always_comb begin
    wb = wq_q;
    if (speed == 0)
      for (int i = width - 2; i >= 0; i--) wb[i] = wb[i+1] ^ wq_q[i];
    else
      for (int s = 1; s < width; s = s * 2) wb = wb ^ (wb >> s);
  end
  assign LEVEL    = wb - rb_q;
  assign EMPTY    = LEVEL == '0;
  assign RD_VALID = !EMPTY && !err_q;
  assign RADDR    = rb_q[width-2:0];
  assign RPTR_G   = rptr_q;
  assign ERR      = err_q;
  assign pop      = RD_VALID && RD_READY;
  assign rb_d     = pop ? rb_q + width'(1) : rb_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      wq_q   <= '0;
      rb_q   <= '0;
      rptr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wq_q   <= WPTR_G;
      rb_q   <= rb_d;
      rptr_q <= rb_d ^ (rb_d >> 1);
      err_q  <= err_q || (LEVEL > half);
    end
  end
endmodule

// File: tb/tb_gray_fifo_rd_side.sv
// tb_gray_fifo_rd_side: scoreboard bench for gray_fifo_rd_side, one instance per speed setting
module tb_gray_fifo_rd_side;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [3:0] WPTR_G = '0;
  logic RD_READY = 1'b0;
  logic       rv[3], em[3], er[3];
  logic [2:0] ra[3];
  logic [3:0] rp[3], lv[3];
  int checks = 0;
  int errors = 0;
  int m_w = 0, m_rb = 0, w = 0;
  bit m_err = 1'b0;
  typedef struct {
    bit rst;
    bit v, e, err;
    int lvl, raddr, rptr;
  } exp_t;
  exp_t exq[$];
  always #5 CLK = ~CLK;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    gray_fifo_rd_side #(.width(4), .speed(g)) dut (
      .CLK(CLK), .RST(RST), .WPTR_G(WPTR_G), .RD_READY(RD_READY),
      .RD_VALID(rv[g]), .RADDR(ra[g]), .RPTR_G(rp[g]), .EMPTY(em[g]),
      .LEVEL(lv[g]), .ERR(er[g])
    );
  end
  function automatic int gray(int b);
    return (b ^ (b >> 1)) & 15;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Drive one cycle of inputs, advance the occupancy model, queue the post-edge expectation.
  task automatic step(int wn, bit rdy, bit r);
    int lvl;
    bit pop;
    exp_t x;
    WPTR_G = 4'(gray(wn));
    RD_READY = rdy;
    RST = r;
    lvl = (m_w - m_rb) & 15;
    pop = lvl != 0 && !m_err && rdy;
    @(posedge CLK);
    if (r) begin
      m_w = 0; m_rb = 0; m_err = 0;
    end else begin
      m_err = m_err || lvl > 8;
      m_rb = (m_rb + int'(pop)) & 15;
      m_w = wn & 15;
    end
    x.rst = r;
    x.lvl = (m_w - m_rb) & 15;
    x.e = x.lvl == 0;
    x.err = m_err;
    x.v = !x.e && !m_err;
    x.raddr = m_rb & 7;
    x.rptr = gray(m_rb);
    exq.push_back(x);
    #1;
  endtask
  logic [3:0] prev_rp[3];
  bit prev_ok = 1'b0;
  always @(negedge CLK) begin
    if (exq.size() != 0) begin
      exp_t x;
      x = exq.pop_front();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("s%0d rd_valid", k), 32'(rv[k]), 32'(x.v));
        chk($sformatf("s%0d empty", k), 32'(em[k]), 32'(x.e));
        chk($sformatf("s%0d level", k), 32'(lv[k]), 32'(x.lvl));
        chk($sformatf("s%0d raddr", k), 32'(ra[k]), 32'(x.raddr));
        chk($sformatf("s%0d rptr_g", k), 32'(rp[k]), 32'(x.rptr));
        chk($sformatf("s%0d err", k), 32'(er[k]), 32'(x.err));
        if (prev_ok && !x.rst)
          chk($sformatf("s%0d rptr_hamming_le1", k), 32'($countones(prev_rp[k] ^ rp[k]) <= 1), 32'd1);
        prev_rp[k] = rp[k];
      end
      prev_ok = 1'b1;
    end
  end
  initial begin
    step(0, 1, 1);
    step(0, 1, 1);
    chk("reset level", 32'(lv[2]), 0);
    chk("reset rptr", 32'(rp[2]), 0);
    step(1, 0, 0);
    step(2, 0, 0);
    step(3, 0, 0);
    chk("fill level3", 32'(lv[2]), 3);
    repeat (3) step(3, 1, 0);
    chk("drain empty", 32'(em[2]), 1);
    chk("drain rptr", 32'(rp[2]), 2);
    for (int i = 4; i <= 15; i++) step(i, 1, 0);
    repeat (10) step(15, 1, 0);
    chk("prewrap rptr", 32'(rp[2]), 8);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("wrap rptr", 32'(rp[2]), 0);
    chk("wrap level", 32'(lv[2]), 0);
    chk("wrap err", 32'(er[2]), 0);
    step(2, 0, 0);
    chk("simul pre level", 32'(lv[2]), 2);
    step(3, 1, 0);
    chk("simul level", 32'(lv[2]), 2);
    repeat (3) step(3, 1, 0);
    step(11, 0, 0);
    chk("full level", 32'(lv[2]), 8);
    chk("full valid", 32'(rv[2]), 1);
    chk("full err", 32'(er[2]), 0);
    step(12, 0, 0);
    step(12, 0, 0);
    step(12, 1, 0);
    step(12, 1, 0);
    chk("ovf err", 32'(er[2]), 1);
    chk("ovf valid", 32'(rv[2]), 0);
    chk("ovf level", 32'(lv[2]), 9);
    chk("ovf rptr held", 32'(rp[2]), 2);
    step(0, 0, 1);
    chk("rst clears err", 32'(er[2]), 0);
    w = 0;
    for (int c = 0; c < 10000; c++) begin
      bit rdy;
      int adv;
      rdy = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 499) == 0) begin
        w = 0;
        step(0, rdy, 1);
      end else begin
        adv = $urandom_range(0, 2);
        if ($urandom_range(0, 999) == 0) adv = 9;
        else if (((w + adv - m_rb) & 15) > 8) adv = 0;
        w = (w + adv) & 15;
        step(w, rdy, 0);
      end
    end
    step(w, 0, 0);
    @(negedge CLK);
    #1;
    chk("scoreboard drained", 32'(exq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
